example_z_collector: RTL and testbench

//   Downstream stage of the example DUT: captures each z result with a valid strobe and

---
 rtl/example_z_collector.sv | 96 +++++++++
 tb/tb_example_z_collector.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/example_z_collector.sv
// Result collector: buffers z samples in a first-word fall-through FIFO for a slower consumer.
// Optional drop counter is enabled with `define EXAMPLE_Z_DROP_CNT_EN; otherwise drop_cnt reads 0.
module example_z_collector #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CSUM_W = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_in_valid,
  input  logic [DATA_W-1:0]          i_in_data,
  output logic                       o_in_ready,
  output logic                       o_out_valid,
  output logic [DATA_W-1:0]          o_out_data,
  input  logic                       i_out_ready,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [CSUM_W-1:0]          o_checksum,
  output logic                       o_overflow,
  output logic [15:0]                o_drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CSUM_W-1:0] r_checksum;
  logic              r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_drop;

  // Handshakes decode only registered state, so no input reaches an output combinationally.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = i_in_valid && !w_full;
  assign w_pop   = i_out_ready && !w_empty;
  assign w_drop  = i_in_valid && w_full;

  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) begin
      r_mem[r_wr_ptr] <= i_in_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_checksum <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
        r_checksum <= r_checksum + CSUM_W'(r_mem[r_rd_ptr]);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef EXAMPLE_Z_DROP_CNT_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`else
  assign o_drop_cnt = 16'h0;
`endif

  assign o_in_ready  = !w_full;
  assign o_out_valid = !w_empty;
  assign o_out_data  = r_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign o_checksum  = r_checksum;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_example_z_collector.sv
// Directed bench for example_z_collector: ordering, full/drop, wrap, checksum wrap, reset priority.
module tb_example_z_collector;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic [7:0]  inData;
  logic        inReady;
  logic        outValid;
  logic [7:0]  outData;
  logic        outReady;
  logic [2:0]  count;
  logic [15:0] checksum;
  logic        overflow;
  logic [15:0] dropCnt;

  int vectors;
  int miscompares;
  logic [15:0] expCsum;
  logic [15:0] expDrop;
  logic [7:0]  model[$];

  example_z_collector #(.DATA_W(8), .DEPTH(4), .CSUM_W(16)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_in_valid (inValid),
    .i_in_data  (inData),
    .o_in_ready (inReady),
    .o_out_valid(outValid),
    .o_out_data (outData),
    .i_out_ready(outReady),
    .o_count    (count),
    .o_checksum (checksum),
    .o_overflow (overflow),
    .o_drop_cnt (dropCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    inValid  = v;
    inData   = d;
    outReady = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    expCsum     = 16'h0;
`ifdef EXAMPLE_Z_DROP_CNT_EN
    expDrop = 16'd1;
`else
    expDrop = 16'd0;
`endif

    // Reset held for two edges
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    step();
    step();
    rst = 1'b0;
    checkOutput("rst_out_valid", 32'(outValid), 32'd0);
    checkOutput("rst_in_ready", 32'(inReady), 32'd1);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_checksum", 32'(checksum), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_drop_cnt", 32'(dropCnt), 32'd0);

    // Three pushes, then drain in order
    applyStimulus(1'b1, 8'h11, 1'b0);
    #1;
    checkOutput("no_bypass", 32'(outValid), 32'd0);
    step();
    checkOutput("lat_out_valid", 32'(outValid), 32'd1);
    checkOutput("lat_out_data", 32'(outData), 32'h11);
    applyStimulus(1'b1, 8'h22, 1'b0);
    step();
    applyStimulus(1'b1, 8'h33, 1'b0);
    step();
    checkOutput("t2_count3", 32'(count), 32'd3);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t2_pop0", 32'(outData), 32'h11);
    step();
    checkOutput("t2_count2", 32'(count), 32'd2);
    checkOutput("t2_pop1", 32'(outData), 32'h22);
    step();
    checkOutput("t2_pop2", 32'(outData), 32'h33);
    step();
    checkOutput("t2_count0", 32'(count), 32'd0);
    checkOutput("t2_empty", 32'(outValid), 32'd0);
    checkOutput("t2_checksum", 32'(checksum), 32'h0066);
    step();
    checkOutput("t2_empty_pop_ignored", 32'(checksum), 32'h0066);
    expCsum = 16'h0066;

    // Fill to full, drop the fifth sample
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      step();
    end
    checkOutput("t3_full_in_ready", 32'(inReady), 32'd0);
    checkOutput("t3_full_count", 32'(count), 32'd4);
    checkOutput("t3_no_overflow_yet", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 8'h05, 1'b0);
    step();
    checkOutput("t3_drop_count", 32'(count), 32'd4);
    checkOutput("t3_overflow", 32'(overflow), 32'd1);
    checkOutput("t3_drop_cnt", 32'(dropCnt), 32'(expDrop));
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("t3_in_ready_not_comb", 32'(inReady), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("t3_drain%0d", i), 32'(outData), 32'(i));
      step();
      expCsum = expCsum + 16'(i);
      if (i == 1) checkOutput("t3_in_ready_after_pop", 32'(inReady), 32'd1);
    end
    checkOutput("t3_drained", 32'(count), 32'd0);
    checkOutput("t3_checksum", 32'(checksum), 32'(expCsum));
    checkOutput("t3_overflow_sticky", 32'(overflow), 32'd1);

    // Concurrent push and pop at count=2, pointers wrap twice overall
    model.delete();
    applyStimulus(1'b1, 8'hAA, 1'b0);
    step();
    model.push_back(8'hAA);
    applyStimulus(1'b1, 8'hBB, 1'b0);
    step();
    model.push_back(8'hBB);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'hC0 + 8'(i), 1'b1);
      checkOutput($sformatf("t4_head%0d", i), 32'(outData), 32'(model[0]));
      step();
      expCsum = expCsum + 16'(model[0]);
      void'(model.pop_front());
      model.push_back(8'hC0 + 8'(i));
      checkOutput($sformatf("t4_count%0d", i), 32'(count), 32'd2);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("t4_tail%0d", i), 32'(outData), 32'(model[0]));
      step();
      expCsum = expCsum + 16'(model[0]);
      void'(model.pop_front());
    end
    checkOutput("t4_checksum", 32'(checksum), 32'(expCsum));

    // Clear, then wrap the checksum with 258 pops of FF
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    step();
    rst = 1'b0;
    checkOutput("t5_rst_overflow", 32'(overflow), 32'd0);
    checkOutput("t5_rst_drop_cnt", 32'(dropCnt), 32'd0);
    checkOutput("t5_rst_checksum", 32'(checksum), 32'd0);
    applyStimulus(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 258; i++) step();
    checkOutput("t5_csum_257", 32'(checksum), 32'h0000FFFF);
    checkOutput("t5_count1", 32'(count), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    step();
    checkOutput("t5_csum_258", 32'(checksum), 32'(16'(258 * 255)));
    checkOutput("t5_count0", 32'(count), 32'd0);

    // Reset beats a simultaneous push and pop
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 8'h40 + 8'(i), 1'b0);
      step();
    end
    checkOutput("t6_pre_count", 32'(count), 32'd3);
    rst = 1'b1;
    applyStimulus(1'b1, 8'h77, 1'b1);
    step();
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t6_count", 32'(count), 32'd0);
    checkOutput("t6_out_valid", 32'(outValid), 32'd0);
    checkOutput("t6_checksum", 32'(checksum), 32'd0);
    checkOutput("t6_in_ready", 32'(inReady), 32'd1);
    step();
    checkOutput("t6_still_empty", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
